// File: rtl/fetch_queue.sv
// Instruction-fetch stage: PC state machine, I-form branch resolution at fetch,
// and a DEPTH-entry queue presenting {pc, instr} to decode over valid/ready.
module fetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  // state | meaning
  // RUN   | fetch enabled, pushes whenever the queue has (or is making) room
  // HALT  | all-zero word seen; PC holds, queue keeps draining to decode
  typedef enum logic {RUN, HALT} state_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, seq_pc, li_addr;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [31:0]       mem_instr [DEPTH];
  logic [63:0]       li_ext;
  logic              pop, push, flush, is_branch;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign halted    = (state == HALT);
  assign out_pc    = mem_pc[rd_ptr];
  assign out_instr = mem_instr[rd_ptr];
  assign pop       = out_valid & out_ready;

  // LI is sign-extended through 64 bits, then truncated to the address width.
  assign is_branch = (imem_data[31:26] == 6'd18);
  assign li_ext    = {{40{imem_data[25]}}, imem_data[25:2]};
  assign li_addr   = li_ext[ADDR_W-1:0];

  always_comb begin
    seq_pc = pc + ADDR_W'(1);
    if (is_branch) begin
      if (imem_data[1]) seq_pc = li_addr;
      else              seq_pc = pc + li_addr;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush      = 1'b1;
      pc_next    = redirect_target;
      state_next = RUN;
    end else if (state == RUN) begin
      if (imem_data == 32'd0) begin
        state_next = HALT;
      end else if ((count < CNT_W'(DEPTH)) || pop) begin
        push    = 1'b1;
        pc_next = seq_pc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is cleared on reset so the head fields read as zero out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (push) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage for the uPower core. It replaces the single-cycle "PC + 1 or jump" update with a program-counter state machine. Fetched instructions are buffered in a FIFO of configurable depth and handed to decode over a valid/ready handshake. Unconditional I-form branches (opcode 18) are resolved at fetch. Taken conditional branches arrive from execute as a redirect that flushes the queue. An all-zero word stops fetch until a redirect arrives.

## Interface
- ADDR_W, 32, PC / instruction-memory address width (word address; PC steps by 1)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 0, PC value loaded at reset

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  word address to instruction memory; equals PC
- imem_data  in  32  instruction at imem_addr, combinational, same cycle
- redirect_valid  in  1  taken branch from execute; 1-cycle pulse
- redirect_target  in  ADDR_W  new PC when redirect_valid=1
- out_valid  out  1  queue head is valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_pc  out  ADDR_W  PC of head instruction
- halted  out  1  fetch stopped on an all-zero word

## Operation
- State machine has two states:
  - RUN: fetch enabled.
  - HALT: no fetch; PC holds; queue still drains to decode.
- Pop: out_valid & out_ready. The head is removed at the clock edge.
- Push, in RUN with no redirect: (count < DEPTH) | pop.
  - Pushes {PC, imem_data} at the tail.
- PC update on a push. Opcode is imem_data[31:26]; LI is [25:2]; AA is [1].
  - Opcode 18, AA=1: PC ← sext(LI).
  - Opcode 18, AA=0: PC ← PC + sext(LI).
  - Otherwise: PC ← PC + 1.
  - LI is sign-extended (or truncated) to ADDR_W. Results wrap modulo 2^ADDR_W.
- No push in RUN: PC holds.
- imem_data == 0 in RUN with no redirect:
  - The word is not pushed and PC holds.
  - State goes to HALT; halted=1 from the next cycle.
- redirect_valid=1, highest priority, any state:
  - PC ← redirect_target.
  - count ← 0, dropping all entries including any head popped that cycle.
  - No push; state ← RUN.
- Pop, push, redirect and halt are all decided from values present before the edge.

## Timing
- Reset values (asynchronous on reset_n=0):
  - PC = RESET_PC; imem_addr = RESET_PC.
  - count = 0; out_valid = 0; halted = 0; state = RUN.
  - out_instr and out_pc are 0.
- Latency: an instruction fetched in cycle N appears at the head no earlier than cycle N+1.
  - With out_ready held at 1, decode receives one instruction per cycle.
- Full (count=DEPTH) with out_ready=1: pop and push in the same cycle; count stays DEPTH.
- Full with out_ready=0: no push; PC holds; imem_addr stable.
- Empty: out_valid=0; out_instr and out_pc hold their last values (don't-care).
- Redirect while full or while halted: same flush behaviour. The first fetch from the target occurs in the cycle after the redirect.
- Reset asserted mid-operation: takes effect immediately and discards queue contents. Fetch resumes from RESET_PC on the first edge after reset_n rises.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

## Test plan
- Sequential fetch: imem[i] = 0x38000000 | i, out_ready=1.
  - After reset: out_pc = 0,1,2,3 on consecutive cycles from cycle 1.
  - out_valid remains 1 after cycle 1.
- Backpressure, DEPTH=4, out_ready=0:
  - count reaches 4 after 4 cycles; imem_addr holds at 4.
  - Raising out_ready gives pops in order 0..3, then 4, with no bubble.
- Branches:
  - Relative: word 0x4BFFFFF8 at PC 10 (LI=-2, AA=0). Next fetch address is 8.
  - Absolute: word 0x48000042 (LI=16, AA=1). Next fetch address is 16.
  - Wrap: with ADDR_W=8, PC=255 with a non-branch word gives next PC 0.
- Redirect flush:
  - Queue holds 3 entries; pulse redirect_valid with target 0x40 while out_ready=1.
  - Next cycle out_valid=0; the following cycle out_pc=0x40.
  - None of the old entries appears.
- Halt:
  - imem[5]=0: entries 0..4 drain; halted=1; imem_addr stays 5; no entry with pc 5 is output.
  - Redirect to 7: halted=0 next cycle; output resumes at pc 7.
- Reset mid-stream:
  - reset_n low for 1 cycle with 2 entries queued: out_valid=0 and halted=0 immediately.
  - After release, output restarts at RESET_PC.
